// File: rtl/exception_wb_unit_if.sv
`default_nettype none
// =============================================================================
// exception_wb_unit_if
// Writeback-boundary bundle: ALU and mult/div result streams in, writeback and
// exception status out.
// Revision: 1.0
// =============================================================================
interface exception_wb_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ovf;
    logic              in_rtype;
    logic [4:0]        in_aluop;
    logic [REG_W-1:0]  in_rd;
    logic [DATA_W-1:0] in_data;
    logic              md_done;
    logic              md_exc;
    logic              md_isdiv;
    logic [REG_W-1:0]  md_rd;
    logic [DATA_W-1:0] md_data;
    logic              irq_ack;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              exc_pending;
    logic [2:0]        exc_code;
    logic [CNT_W-1:0]  exc_count;
    logic              proto_err;

    modport master (
        output in_valid, in_ovf, in_rtype, in_aluop, in_rd, in_data,
        output md_done, md_exc, md_isdiv, md_rd, md_data, irq_ack,
        input  wb_we, wb_rd, wb_data, stall, exc_pending, exc_code, exc_count, proto_err
    );

    modport slave (
        input  in_valid, in_ovf, in_rtype, in_aluop, in_rd, in_data,
        input  md_done, md_exc, md_isdiv, md_rd, md_data, irq_ack,
        output wb_we, wb_rd, wb_data, stall, exc_pending, exc_code, exc_count, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/exception_wb_unit.sv
`default_nettype none
// =============================================================================
// exception_wb_unit
// Merges ALU and mult/div results into one writeback slot, redirecting
// arithmetic exceptions to the status register; colliding mult/div results
// are queued and drained while the pipeline is stalled.
// Revision: 1.0
// =============================================================================
module exception_wb_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int STATUS_REG = 30,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic          clock,
    input  wire logic          reset,
    exception_wb_unit_if.slave bus
);
    localparam int                C_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                C_CNT_BITS  = C_PTR_W + 1;
    localparam int                C_ENTRY_W   = DATA_W + REG_W + 2;
    localparam logic [C_CNT_BITS-1:0] C_FULL  = C_CNT_BITS'(DEPTH);
    localparam logic [REG_W-1:0]  C_STATUS_RD = REG_W'(STATUS_REG);
    localparam logic [4:0]        C_OP_ADD    = 5'd0;
    localparam logic [4:0]        C_OP_SUB    = 5'd1;
    localparam logic [2:0]        C_CODE_NONE = 3'd0;
    localparam logic [2:0]        C_CODE_ADD  = 3'd1;
    localparam logic [2:0]        C_CODE_ADDI = 3'd2;
    localparam logic [2:0]        C_CODE_SUB  = 3'd3;
    localparam logic [2:0]        C_CODE_MUL  = 3'd4;
    localparam logic [2:0]        C_CODE_DIV  = 3'd5;
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};

    logic [C_ENTRY_W-1:0]  r_mem [DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_BITS-1:0] r_count;

    logic                  r_wb_we;
    logic [REG_W-1:0]      r_wb_rd;
    logic [DATA_W-1:0]     r_wb_data;
    logic                  r_exc_pending;
    logic [2:0]            r_exc_code;
    logic [CNT_W-1:0]      r_exc_count;
    logic                  r_proto_err;

    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_drop;
    logic [C_ENTRY_W-1:0]  w_head;
    logic [C_ENTRY_W-1:0]  w_new_entry;
    logic [2:0]            w_alu_code;
    logic                  w_src_valid;
    logic                  w_src_exc;
    logic [2:0]            w_src_code;
    logic [REG_W-1:0]      w_src_rd;
    logic [DATA_W-1:0]     w_src_data;
    logic                  w_redirect;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == C_FULL);
    assign w_pop        = !bus.in_valid && !w_fifo_empty;
    // md_done only bypasses the queue when the slot is free and nothing is queued ahead of it
    assign w_push_req   = bus.md_done && (bus.in_valid || !w_fifo_empty);
    assign w_push       = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop       = w_push_req && !w_push;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_new_entry  = {bus.md_exc, bus.md_isdiv, bus.md_rd, bus.md_data};

    always_comb begin
        w_alu_code = C_CODE_NONE;
        if (bus.in_aluop == C_OP_ADD) begin
            w_alu_code = bus.in_rtype ? C_CODE_ADD : C_CODE_ADDI;
        end else if (bus.in_aluop == C_OP_SUB) begin
            w_alu_code = C_CODE_SUB;
        end
    end

    always_comb begin
        w_src_valid = 1'b0;
        w_src_exc   = 1'b0;
        w_src_code  = C_CODE_NONE;
        w_src_rd    = '0;
        w_src_data  = '0;
        if (bus.in_valid) begin
            w_src_valid = 1'b1;
            w_src_exc   = bus.in_ovf;
            w_src_code  = w_alu_code;
            w_src_rd    = bus.in_rd;
            w_src_data  = bus.in_data;
        end else if (!w_fifo_empty) begin
            w_src_valid = 1'b1;
            w_src_exc   = w_head[C_ENTRY_W-1];
            w_src_code  = w_head[C_ENTRY_W-2] ? C_CODE_DIV : C_CODE_MUL;
            w_src_rd    = w_head[DATA_W +: REG_W];
            w_src_data  = w_head[DATA_W-1:0];
        end else if (bus.md_done) begin
            w_src_valid = 1'b1;
            w_src_exc   = bus.md_exc;
            w_src_code  = bus.md_isdiv ? C_CODE_DIV : C_CODE_MUL;
            w_src_rd    = bus.md_rd;
            w_src_data  = bus.md_data;
        end
    end

    // An overflow on an ALU op without an exception code is written back unchanged
    assign w_redirect = w_src_valid && w_src_exc && (w_src_code != C_CODE_NONE);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb_we       <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_exc_pending <= 1'b0;
            r_exc_code    <= C_CODE_NONE;
            r_exc_count   <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_wb_we   <= w_src_valid;
            r_wb_rd   <= w_redirect ? C_STATUS_RD : w_src_rd;
            r_wb_data <= w_redirect ? {{(DATA_W-3){1'b0}}, w_src_code} : w_src_data;
            if (w_redirect) begin
                r_exc_pending <= 1'b1;
                r_exc_code    <= w_src_code;
                if (r_exc_count != C_CNT_MAX) begin
                    r_exc_count <= r_exc_count + 1'b1;
                end
            end else if (bus.irq_ack) begin
                r_exc_pending <= 1'b0;
            end
            if ((bus.in_valid && !w_fifo_empty) || w_drop) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.wb_we       = r_wb_we;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.stall       = !w_fifo_empty;
    assign bus.exc_pending = r_exc_pending;
    assign bus.exc_code    = r_exc_code;
    assign bus.exc_count   = r_exc_count;
    assign bus.proto_err   = r_proto_err;
endmodule
`default_nettype wire
